// File: rtl/alu_core_pkg.sv
// Shared definitions for the pipelined ALU core family: opcodes, instruction
// field positions and decode predicates.
package alu_core_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_ADDI = 4'd8;
   localparam logic [3:0] OP_LUI  = 4'd9;

   localparam int OP_LSB  = 28;
   localparam int RD_LSB  = 24;
   localparam int RS1_LSB = 20;
   localparam int RS2_LSB = 16;
   localparam int IMM_LSB = 0;

   // Opcodes above LUI are all treated as no-operation.
   function automatic logic is_nop(input logic [3:0] op);
      return (op > OP_LUI);
   endfunction

   function automatic logic uses_rs1(input logic [3:0] op);
      return (op <= OP_ADDI);
   endfunction

   function automatic logic uses_rs2(input logic [3:0] op);
      return (op <= OP_SLT);
   endfunction

endpackage

// File: rtl/alu_core_exec.sv
// Combinational ALU for the pipelined core: op, operands and immediate in,
// DW-bit result out. Arithmetic wraps modulo 2^DW.
module alu_core_exec
   import alu_core_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [3:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [15:0]   imm,
   output logic [DW-1:0] result
);

   localparam int SW = $clog2(DW);

   // Result select by opcode; NOP codes produce zero and are never retired.
   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLL:  result = a << b[SW-1:0];
         OP_SRL:  result = a >> b[SW-1:0];
         OP_SLT:  result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_ADDI: result = a + DW'($signed(imm));
         OP_LUI:  result = (DW >= 32) ? DW'({imm, 16'd0}) : DW'(imm);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/pipelined_alu_core.sv
// Three-stage IF/ID/EX register-register ALU pipeline fed by a valid/ready
// instruction stream; RAW hazards are forwarded (FWD=1) or interlocked (FWD=0).
module pipelined_alu_core
   import alu_core_pkg::*;
#(
   parameter int DW  = 32,
   parameter int FWD = 1,
   parameter int CW  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [31:0]   in_instr,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] aluout,
   output logic [3:0]    out_rd,
   output logic [CW-1:0] retire_cnt,
   output logic [CW-1:0] stall_cnt
);

   logic          if_valid_r;
   logic [31:0]   if_instr_r;
   logic [DW-1:0] rf_r [16];

   logic          ex_valid_r;
   logic [3:0]    ex_op_r;
   logic [3:0]    ex_rd_r;
   logic [DW-1:0] ex_a_r;
   logic [DW-1:0] ex_b_r;
   logic [15:0]   ex_imm_r;
   logic [DW-1:0] ex_res_s;

   logic [3:0]    id_op_s;
   logic [3:0]    id_rd_s;
   logic [3:0]    id_rs1_s;
   logic [3:0]    id_rs2_s;
   logic [15:0]   id_imm_s;
   logic [DW-1:0] id_a_s;
   logic [DW-1:0] id_b_s;
   logic          haz1_s;
   logic          haz2_s;
   logic          stall_s;

   assign id_op_s  = if_instr_r[OP_LSB  +: 4];
   assign id_rd_s  = if_instr_r[RD_LSB  +: 4];
   assign id_rs1_s = if_instr_r[RS1_LSB +: 4];
   assign id_rs2_s = if_instr_r[RS2_LSB +: 4];
   assign id_imm_s = if_instr_r[IMM_LSB +: 16];

   alu_core_exec #(.DW(DW)) u_exec (
      .op     (ex_op_r),
      .a      (ex_a_r),
      .b      (ex_b_r),
      .imm    (ex_imm_r),
      .result (ex_res_s)
   );

   // Hazard detect against EX and operand select; forwarding always beats the register file.
   always_comb begin
      haz1_s = if_valid_r && ex_valid_r && uses_rs1(id_op_s) &&
               (id_rs1_s != 4'd0) && (id_rs1_s == ex_rd_r);
      haz2_s = if_valid_r && ex_valid_r && uses_rs2(id_op_s) &&
               (id_rs2_s != 4'd0) && (id_rs2_s == ex_rd_r);
      stall_s = (FWD == 0) && (haz1_s || haz2_s);
      if ((FWD != 0) && haz1_s) begin
         id_a_s = ex_res_s;
      end else begin
         id_a_s = rf_r[id_rs1_s];
      end
      if ((FWD != 0) && haz2_s) begin
         id_b_s = ex_res_s;
      end else begin
         id_b_s = rf_r[id_rs2_s];
      end
      in_ready = !if_valid_r || !stall_s;
   end

   // Pipeline registers, register file writeback and counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if_valid_r <= 1'b0;
         if_instr_r <= 32'd0;
         ex_valid_r <= 1'b0;
         ex_op_r    <= 4'd0;
         ex_rd_r    <= 4'd0;
         ex_a_r     <= '0;
         ex_b_r     <= '0;
         ex_imm_r   <= 16'd0;
         out_valid  <= 1'b0;
         aluout     <= '0;
         out_rd     <= 4'd0;
         retire_cnt <= '0;
         stall_cnt  <= '0;
         for (int i = 0; i < 16; i++) begin
            rf_r[i] <= '0;
         end
      end else begin
         if (!stall_s) begin
            if_valid_r <= in_valid;
            if (in_valid) begin
               if_instr_r <= in_instr;
            end
         end
         // NOPs are dropped here so EX only ever holds retiring work.
         ex_valid_r <= if_valid_r && !stall_s && !is_nop(id_op_s);
         if (if_valid_r && !stall_s) begin
            ex_op_r  <= id_op_s;
            ex_rd_r  <= id_rd_s;
            ex_a_r   <= id_a_s;
            ex_b_r   <= id_b_s;
            ex_imm_r <= id_imm_s;
         end
         out_valid <= ex_valid_r;
         if (ex_valid_r) begin
            aluout     <= ex_res_s;
            out_rd     <= ex_rd_r;
            retire_cnt <= retire_cnt + CW'(1);
            if (ex_rd_r != 4'd0) begin
               rf_r[ex_rd_r] <= ex_res_s;
            end
         end
         if (stall_s) begin
            stall_cnt <= stall_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipelined_alu_core.sv
// Bench for pipelined_alu_core: a forwarding DW=32 core and an interlocking
// DW=16/CW=4 core, checked against an in-order architectural model.
module tb_pipelined_alu_core;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sel = 1'b0;
   logic        drv_valid = 1'b0;
   logic [31:0] drv_instr = 32'd0;
   logic        chk_en = 1'b0;

   logic        f_in_valid, f_in_ready, f_out_valid;
   logic [31:0] f_aluout;
   logic [3:0]  f_out_rd;
   logic [15:0] f_retire, f_stall;
   logic        s_in_valid, s_in_ready, s_out_valid;
   logic [15:0] s_aluout;
   logic [3:0]  s_out_rd;
   logic [3:0]  s_retire, s_stall;

   logic        mon_ready, mon_valid;
   logic [63:0] mon_alu;
   logic [3:0]  mon_rd;
   logic [15:0] mon_ret, mon_stall;

   always #5 clk = ~clk;

   assign f_in_valid = drv_valid && !sel;
   assign s_in_valid = drv_valid && sel;
   assign mon_ready  = sel ? s_in_ready  : f_in_ready;
   assign mon_valid  = sel ? s_out_valid : f_out_valid;
   assign mon_alu    = sel ? {48'd0, s_aluout} : {32'd0, f_aluout};
   assign mon_rd     = sel ? s_out_rd : f_out_rd;
   assign mon_ret    = sel ? {12'd0, s_retire} : f_retire;
   assign mon_stall  = sel ? {12'd0, s_stall}  : f_stall;

   pipelined_alu_core #(.DW(32), .FWD(1), .CW(16)) u_f (
      .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_instr(drv_instr),
      .in_ready(f_in_ready), .out_valid(f_out_valid), .aluout(f_aluout),
      .out_rd(f_out_rd), .retire_cnt(f_retire), .stall_cnt(f_stall));

   pipelined_alu_core #(.DW(16), .FWD(0), .CW(4)) u_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_instr(drv_instr),
      .in_ready(s_in_ready), .out_valid(s_out_valid), .aluout(s_aluout),
      .out_rd(s_out_rd), .retire_cnt(s_retire), .stall_cnt(s_stall));

   typedef struct {int cyc; logic [3:0] rd; logic [63:0] val;} exp_t;

   int n_vec = 0, n_cmp = 0, n_err = 0;
   int cyc = 0, last_acc = 0, rdy_low = 0;
   exp_t expq[$];
   logic [63:0] got_v[$];
   logic [3:0]  got_rd[$];
   int          got_c[$];

   // architectural model state
   int m_dw = 32, m_cw = 16, m_retire = 0, m_stall = 0;
   bit m_fwd = 1'b1, prev_has = 1'b0, prev_nop = 1'b1;
   int prev_rd = 0, prev_ex = 0;
   logic [63:0] arch [16];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic chk_got(input string nm, input int idx, input logic [63:0] exp);
      if (idx < got_v.size()) chk(nm, got_v[idx], exp);
      else begin
         n_cmp++; n_err++;
         $display("FAIL %s: result %0d never appeared, required 0x%0h", nm, idx, exp);
      end
   endtask

   task automatic chk_gap(input string nm, input int i, input int j, input int d);
      if (j < got_c.size()) chk(nm, 64'(got_c[j] - got_c[i]), 64'(d));
      else begin
         n_cmp++; n_err++;
         $display("FAIL %s: result %0d never appeared, required gap %0d", nm, j, d);
      end
   endtask

   function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2, input int imm);
      return {4'(op), 4'(rd), 4'(rs1), 4'(rs2), 16'(imm)};
   endfunction

   function automatic logic [63:0] model_exec(input int dw, input logic [3:0] op,
                                              input logic [63:0] a, input logic [63:0] b,
                                              input logic [15:0] imm);
      logic [63:0] m, r;
      longint sa, sb;
      int sh;
      m  = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
      sa = longint'(a << (64 - dw)) >>> (64 - dw);
      sb = longint'(b << (64 - dw)) >>> (64 - dw);
      sh = int'(b % 64'(dw));
      case (op)
         4'd0: r = a + b;
         4'd1: r = a - b;
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = a << sh;
         4'd6: r = (a & m) >> sh;
         4'd7: r = (sa < sb) ? 64'd1 : 64'd0;
         4'd8: r = a + {{48{imm[15]}}, imm};
         4'd9: r = (dw >= 32) ? ({48'd0, imm} << 16) : {48'd0, imm};
         default: r = 64'd0;
      endcase
      return r & m;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) arch[i] = 64'd0;
      expq.delete();
      m_retire = 0; m_stall = 0;
      prev_has = 1'b0; prev_nop = 1'b1; prev_rd = 0; prev_ex = 0;
   endfunction

   // In-order execution; pipeline timing follows from accept edge plus any interlock bubble.
   function automatic void model_accept(input logic [31:0] ins, input int acc);
      logic [3:0] op, rd, rs1, rs2;
      logic [63:0] r;
      bit rd1, rd2, nop;
      int s;
      op = ins[31:28]; rd = ins[27:24]; rs1 = ins[23:20]; rs2 = ins[19:16];
      nop = (op > 4'd9);
      rd1 = (op <= 4'd8) && (rs1 != 4'd0);
      rd2 = (op <= 4'd7) && (rs2 != 4'd0);
      s = 0;
      if (!m_fwd && prev_has && !prev_nop && prev_ex == acc &&
          ((rd1 && int'(rs1) == prev_rd) || (rd2 && int'(rs2) == prev_rd))) s = 1;
      m_stall += s;
      if (!nop) begin
         r = model_exec(m_dw, op, arch[rs1], arch[rs2], ins[15:0]);
         if (rd != 4'd0) arch[rd] = r;
         expq.push_back('{acc + 2 + s, rd, r});
         m_retire++;
      end
      prev_has = 1'b1; prev_nop = nop; prev_rd = int'(rd); prev_ex = acc + 1 + s;
   endfunction

   task automatic send(input logic [31:0] ins);
      int g;
      g = 0;
      drv_valid = 1'b1;
      drv_instr = ins;
      while (!mon_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      if (!mon_ready) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: in_ready 0, required 1 within 20 cycles");
         drv_valid = 1'b0;
      end else begin
         last_acc = cyc + 1;
         model_accept(ins, cyc + 1);
         n_vec++;
         @(negedge clk);
         drv_valid = 1'b0;
      end
   endtask

   task automatic do_reset(input logic s);
      chk_en = 1'b0;
      drv_valid = 1'b0;
      sel = s;
      rst = 1'b0;
      m_dw  = s ? 16 : 32;
      m_cw  = s ? 4 : 16;
      m_fwd = !s;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_clear();
      chk_en = 1'b1;
   endtask

   task automatic drain();
      repeat (6) @(negedge clk);
      chk("drain_empty", 64'(expq.size()), 64'd0);
   endtask

   task automatic clear_got();
      got_v.delete(); got_rd.delete(); got_c.delete();
   endtask

   task automatic chk_counters();
      chk("retire_cnt", {48'd0, mon_ret}, 64'(m_retire % (1 << m_cw)));
      chk("stall_cnt", {48'd0, mon_stall}, 64'(m_stall % (1 << m_cw)));
   endtask

   task automatic rand_stream(input int n);
      int op;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
         op = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 9) : $urandom_range(10, 15);
         send(mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 65535)));
      end
   endtask

   // Output compare: every out_valid strobe must match the next model result on its cycle.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (chk_en) begin
         if (!mon_ready) rdy_low++;
         if (mon_valid) begin
            got_v.push_back(mon_alu); got_rd.push_back(mon_rd); got_c.push_back(cyc);
            if (expq.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL out_valid: got unexpected result 0x%0h, required none", mon_alu);
            end else begin
               e = expq.pop_front();
               chk("out_cycle", 64'(cyc), 64'(e.cyc));
               chk("aluout", mon_alu, e.val);
               chk("out_rd", {60'd0, mon_rd}, {60'd0, e.rd});
            end
         end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
            e = expq.pop_front();
            n_cmp++; n_err++;
            $display("FAIL out_valid: got 0, required result 0x%0h at cycle %0d", e.val, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      @(negedge clk);
      // forwarding core: reset state
      do_reset(1'b0);
      chk("rst_out_valid", {63'd0, mon_valid}, 64'd0);
      chk("rst_aluout", mon_alu, 64'd0);
      chk("rst_out_rd", {60'd0, mon_rd}, 64'd0);
      chk("rst_retire", {48'd0, mon_ret}, 64'd0);
      chk("rst_stall", {48'd0, mon_stall}, 64'd0);
      chk("rst_in_ready", {63'd0, mon_ready}, 64'd1);

      clear_got();
      send(mk(8, 1, 0, 0, 5)); acc0 = last_acc;
      send(mk(8, 2, 0, 0, 7));
      send(mk(0, 3, 1, 2, 0));
      drain();
      chk_got("fwd_r1", 0, 64'd5);
      chk_got("fwd_r2", 1, 64'd7);
      chk_got("fwd_add", 2, 64'd12);
      if (got_c.size() > 0) chk("fwd_latency", 64'(got_c[0]), 64'(acc0 + 2));
      chk_gap("fwd_back_to_back", 0, 2, 2);
      chk("fwd_stall_cnt", {48'd0, mon_stall}, 64'd0);

      clear_got();
      send(mk(8, 1, 0, 0, 'hFFFF));
      send(mk(8, 3, 0, 0, 4));
      send(mk(6, 2, 1, 3, 0));
      send(mk(7, 4, 1, 0, 0));
      drain();
      chk_got("addi_neg1", 0, 64'hFFFF_FFFF);
      chk_got("srl", 2, 64'h0FFF_FFFF);
      chk_got("slt", 3, 64'd1);

      clear_got();
      send(mk(8, 1, 0, 0, 3));
      send(mk(0, 0, 1, 1, 0));
      send(mk(0, 5, 0, 0, 0));
      send(mk(12, 6, 1, 1, 0));
      drain();
      chk_got("r0_write_seen", 1, 64'd6);
      if (got_rd.size() > 1) chk("r0_out_rd", {60'd0, got_rd[1]}, 64'd0);
      chk_got("r0_reads_zero", 2, 64'd0);
      chk("nop_no_out", 64'(got_v.size()), 64'd3);
      chk("retire_literal", {48'd0, mon_ret}, 64'd10);

      rand_stream(400);
      drain();
      chk_counters();

      // reset with two instructions in flight
      send(mk(8, 1, 0, 0, 9));
      send(mk(8, 2, 0, 0, 3));
      do_reset(1'b0);
      chk("mid_rst_retire", {48'd0, mon_ret}, 64'd0);
      chk("mid_rst_aluout", mon_alu, 64'd0);
      repeat (3) @(negedge clk);
      for (int r = 1; r < 16; r++) send(mk(0, r, r, 0, 0));
      drain();
      chk_counters();

      // interlocking DW=16 core
      do_reset(1'b1);
      chk("s_rst_in_ready", {63'd0, mon_ready}, 64'd1);
      chk("s_rst_stall", {48'd0, mon_stall}, 64'd0);
      clear_got();
      rdy_low = 0;
      send(mk(8, 1, 0, 0, 5));
      send(mk(8, 2, 0, 0, 7));
      send(mk(0, 3, 1, 2, 0));
      drain();
      chk_got("ilk_r1", 0, 64'd5);
      chk_got("ilk_r2", 1, 64'd7);
      chk_got("ilk_add", 2, 64'd12);
      chk_gap("ilk_no_bubble", 0, 1, 1);
      chk_gap("ilk_one_bubble", 1, 2, 2);
      chk("ilk_stall_cnt", {48'd0, mon_stall}, 64'd1);
      chk("ilk_ready_low", 64'(rdy_low), 64'd1);

      clear_got();
      send(mk(8, 1, 0, 0, 'h7FFF));
      send(mk(8, 2, 1, 0, 1));
      drain();
      chk_got("addi_wrap", 1, 64'h8000);

      do_reset(1'b1);
      for (int i = 0; i < 17; i++) send(mk(8, (i % 15) + 1, 0, 0, i));
      drain();
      chk("retire_wrap", {48'd0, mon_ret}, 64'd1);

      rand_stream(400);
      drain();
      chk_counters();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipelined_alu_core.md
# pipelined_alu_core

Parametrised three-stage (IF/ID/EX) register-register ALU pipeline: the next generation of the fixed 32-bit three-stage processor core. It accepts a stream of 32-bit instructions over a valid/ready handshake instead of an internal program ROM. It resolves read-after-write hazards by forwarding or by interlock, selectable at elaboration. Every executed instruction is published on `aluout` with a valid strobe, plus retire and stall counters for the bench.

## Interface
Parameters:
- `DW`, 32: datapath and register width (8..64).
- `FWD`, 1: 1 = forward the EX result into ID; 0 = stall ID one cycle on a hazard.
- `CW`, 16: width of the retire and stall counters.

Ports:
- `clk` input 1: single clock, all state on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `in_valid` input 1: instruction valid.
- `in_instr` input 32: instruction; `op[31:28] rd[27:24] rs1[23:20] rs2[19:16] imm[15:0]`.
- `in_ready` output 1: IF register can accept.
- `out_valid` output 1: `aluout` holds a newly executed result this cycle.
- `aluout` output DW: last EX result.
- `out_rd` output 4: destination of that result.
- `retire_cnt` output CW: count of executed non-NOP instructions.
- `stall_cnt` output CW: count of interlock bubbles.

## Operation
- Register file: 16 x DW. `r0` reads 0; writes to `r0` are discarded, but such results still appear on `aluout`.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL: shift by `rs2[$clog2(DW)-1:0]`.
  - 7 SLT: signed, result 1 or 0.
  - 8 ADDI: `rs1` + sign-extended `imm`, truncated or extended to DW.
  - 9 LUI: `imm << 16` when DW ≥ 32, else `imm[DW-1:0]`.
  - 10..15 NOP: no write, no `out_valid`, no retire count.
- Arithmetic wraps modulo 2^DW. No flags.
- IF: registers the instruction on `in_valid && in_ready`.
- ID: reads `rs1`/`rs2` and registers operands, `op`, `rd` and `imm` into EX.
- EX: computes the result, writes `rd` and registers `aluout`, `out_rd` and `out_valid` on the same edge.
- Hazard: the ID instruction reads a non-zero `rs1` or `rs2` equal to the `rd` of a valid non-NOP instruction in EX.
  - FWD=1: the ALU result is muxed into the ID operand. No stall.
  - FWD=0: ID holds, a bubble goes into EX, `in_ready` is 0 for that cycle, and `stall_cnt` increments by 1. The dependency resolves after one bubble.
- Distance-2 dependencies always read the already-written register file. No stall.
- `in_ready = !if_valid || !stall`. An empty IF with no stall is always ready.
- Counters wrap at 2^CW.

## Timing
- Instruction accepted at edge k:
  - edge k+1: enters ID/EX operand register.
  - edge k+2: `aluout`/`out_valid` valid and the register is written.
- Latency is 2 cycles. Throughput is 1 per cycle, except one lost cycle per hazard when FWD=0.
- `out_valid` is a single-cycle strobe per executed instruction. `aluout` and `out_rd` hold their last value otherwise.
- Reset (`rst`=0 at an edge):
  - All pipeline valids cleared.
  - All 16 registers cleared to 0.
  - `aluout`, `out_rd`, `out_valid`, `retire_cnt` and `stall_cnt` cleared to 0.
  - `in_ready` = 1 in the first cycle after release.
- Reset mid-stream discards every in-flight instruction, with no partial writeback. A handshake in the reset cycle is ignored.
- Stall with `in_valid` high: the presented instruction must be held by the source. It is accepted on the first cycle with `in_ready`=1.
- Back-to-back writes to the same `rd`: the youngest value wins. Forwarding always selects EX over the register file.

## Structure
- Shared package `alu_core_pkg`: opcode localparams, instruction field offsets, NOP predicate.
- One sub-module, `alu_core_exec`: combinational ALU (op, a, b, imm → result), reused by later variants.
- Register file, hazard detect and counters live inline in `pipelined_alu_core`.

## Test plan
- Reset, then ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2 back-to-back (FWD=1) → `aluout` 5, 7, 12 on consecutive cycles, starting 2 cycles after the first accept; `stall_cnt`=0.
- Same stream with FWD=0 → results 5, 7, 12, with one bubble before 12; `stall_cnt`=1; `in_ready` low for exactly one cycle.
- ADDI r1,r0,-1 then SRL r2,r1,r3 with r3=4, at DW=32 → 0xFFFFFFFF, then 0x0FFFFFFF; SLT r4,r1,r0 → 1.
- ADD r0,r1,r1 with r1=3 → `aluout`=6 with `out_valid`; a subsequent ADD r5,r0,r0 → 0. NOP opcode 12 → no `out_valid`, `retire_cnt` unchanged.
- Assert `rst`=0 with two instructions in flight → no `out_valid` afterwards, all registers read 0, counters 0.
- DW=16, CW=4: ADDI wrap 0x7FFF+1 → 0x8000; 17 retirements → `retire_cnt`=1.
